mul_pipeline_param: RTL and testbench
=====================================

Name: mul_pipeline_param

Overview:
Parametrised, fully pipelined shift-add multiplier with full-width product, per-transaction signed/unsigned mode and output backpressure. Each pipeline stage adds one partial product. One transaction per clock when not stalled. Used wherever the datapath needs a WIDTH x WIDTH product with a fixed, known latency.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32
PROD_W, 2*WIDTH, product width; derived, not overridable

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous reset, active-low
valid_i  in  1  input operands valid
ready_o  out  1  block can accept input this cycle
a_i  in  WIDTH  multiplicand
b_i  in  WIDTH  multiplier
signed_i  in  1  1 = a_i/b_i are two's complement; 0 = unsigned; sampled with operands
p_o  out  PROD_W  product
valid_o  out  1  p_o valid
ready_i  in  1  downstream accepts p_o this cycle

Behaviour:
- Reset: synchronous, active-low; only clock and reset cross the block boundary as control. When rst_n=0 at a rising edge: all stage valid bits cleared, p_o=0, valid_o=0; all in-flight transactions dropped; valid_i ignored on that edge.
- Advance enable: en = ready_i | ~valid_o. ready_o = en (combinational). When en=0, every stage register (operands, partial sums, sign, valid) holds.
- Accept: transaction captured on an edge where valid_i & ready_o & rst_n.
- Stages: stage 0 registers |a|, |b| and result sign (signed_i & (a_msb ^ b_msb)). Stages 1..WIDTH-1 each conditionally add one shifted partial product. The final stage applies the two's-complement negate when the sign bit is set and drives p_o.
- Latency: WIDTH enabled edges. Accept on edge t with no stall gives valid_o=1 immediately after edge t+WIDTH. Stalls extend latency one cycle per stalled edge.
- Throughput: 1 per cycle. Bubbles, meaning cycles with valid_i=0, propagate as invalid slots and are not collapsed.
- Output handshake: a result is consumed on an edge with valid_o & ready_i. While valid_o=1 and ready_i=0, p_o and valid_o are stable.
- Arithmetic: p_o is the exact PROD_W-bit product with no truncation or overflow.
  - Unsigned max: (2^W-1)^2.
  - Signed extremes: (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), positive and representable. (-2^(W-1))*(2^(W-1)-1) is correct.
  - Zero operand gives 0; the negate of 0 stays 0.
- Operands with valid_i=0 must not affect any stage. Invalid slots carry zero data.
- Reset mid-stall: reset wins and ready_o=1 on the next cycle.

Optional Feature:
Macro MUL_PIPE_USER_EN.
- Defined: extra parameter USER_W (default 4), input user_i[USER_W] and output user_o[USER_W]. user_i is captured with the operands, travels with the same valid/stall control, and appears on user_o aligned with p_o. user_o resets to 0.
- Undefined: no user ports, no extra registers, and behaviour is otherwise identical.

Decomposition:
- Package mul_pipe_pkg:
  - function latency(WIDTH) returning WIDTH
  - function abs_val and function neg for two's-complement handling
  - localparam width limits
- Sub-module mul_pipe_stage, instantiated WIDTH-1 times via generate. It holds one accumulate stage: registers for remaining multiplier bits, shifted multiplicand, partial sum, sign and valid. Each instance has en and rst_n inputs.

Test Plan:
1. WIDTH=8, unsigned 255*255, ready_i=1 -> p_o=0xFE01, valid_o high exactly 8 edges after accept, single-cycle pulse.
2. WIDTH=8 signed:
   - -128*-128 -> 0x4000
   - -1*1 -> 0xFFFF
   - -128*127 -> 0xC080
   - 0*-5 -> 0x0000
   - unsigned 0x80*0x80 -> 0x4000
3. 10 back-to-back random mixed-mode transactions, ready_i=1 -> 10 consecutive valid_o cycles, results in order and matching a reference model; ready_o stays 1.
4. Full pipeline, hold ready_i=0 for 5 cycles while valid_o=1 -> p_o/valid_o stable, ready_o=0, new valid_i not accepted. Release -> all results delivered, none lost or duplicated.
5. Assert rst_n=0 for 1 cycle with 4 transactions in flight -> valid_o=0 and p_o=0 after that edge, no stale result ever appears, and a new transaction after reset yields correct result at latency 8.
6. WIDTH=4 build: unsigned 15*15 -> 0xE1; signed -8*-8 -> 0x40; latency 4 edges; with MUL_PIPE_USER_EN, tag 0xA emerges on user_o aligned with its product.

Source files
------------

// File: rtl/mul_pipe_pkg.sv
// Shared definitions for the pipelined shift-add multiplier.
//
// Contents:
//   MinWidth/MaxWidth   legal operand width range
//   latency()           pipeline latency in enabled clock edges for a given operand width
//   abs_val()           magnitude of a zero-extended operand
//   neg()               two's-complement negate at full product width
//
// Optional feature: MUL_PIPE_USER_EN (see mul_pipeline_param) adds a user sideband.
package mul_pipe_pkg;

    localparam int unsigned MinWidth = 2;
    localparam int unsigned MaxWidth = 32;
    localparam int unsigned MaxProdW = 2 * MaxWidth;

    // One edge into the magnitude stage, WIDTH-1 accumulate stages, then the output stage
    // adds the last partial product; the pipeline depth therefore equals the operand width.
    function automatic int unsigned latency(input int unsigned width);
        return width;
    endfunction

    // x is the operand zero-extended to MaxWidth. Callers keep only the low WIDTH bits;
    // the magnitude of the most negative value (2^(W-1)) still fits in W unsigned bits.
    function automatic logic [MaxWidth-1:0] abs_val(input logic [MaxWidth-1:0] x,
                                                    input logic               is_neg);
        return is_neg ? -x : x;
    endfunction

    function automatic logic [MaxProdW-1:0] neg(input logic [MaxProdW-1:0] x);
        return -x;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One accumulate stage of the shift-add multiplier.
//
// Adds the current multiplicand to the partial sum when bit 0 of the remaining multiplier
// is set, then shifts the multiplicand left and the multiplier right for the next stage.
// Invalid slots load zero data. All state holds while en is low.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   en               pipeline advance enable
//   valid_i..sign_i  slot from the previous stage
//   valid_o..sign_o  registered slot for the next stage
//   user_i/user_o    sideband tag (only with MUL_PIPE_USER_EN)
module mul_pipe_stage
    import mul_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
`ifdef MUL_PIPE_USER_EN
    parameter int unsigned USER_W = 4,
`endif
    localparam int unsigned PROD_W = 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              valid_i,
    input  logic [PROD_W-1:0] mcand_i,
    input  logic [WIDTH-1:0]  mplier_i,
    input  logic [PROD_W-1:0] psum_i,
    input  logic              sign_i,
`ifdef MUL_PIPE_USER_EN
    input  logic [USER_W-1:0] user_i,
    output logic [USER_W-1:0] user_o,
`endif
    output logic              valid_o,
    output logic [PROD_W-1:0] mcand_o,
    output logic [WIDTH-1:0]  mplier_o,
    output logic [PROD_W-1:0] psum_o,
    output logic              sign_o
);

    logic              valid_q;
    logic [PROD_W-1:0] mcand_q;
    logic [WIDTH-1:0]  mplier_q;
    logic [PROD_W-1:0] psum_q;
    logic              sign_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            psum_q   <= '0;
            sign_q   <= 1'b0;
        end else if (en) begin
            valid_q <= valid_i;
            if (valid_i) begin
                psum_q   <= psum_i + (mplier_i[0] ? mcand_i : '0);
                mcand_q  <= {mcand_i[PROD_W-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_i[WIDTH-1:1]};
                sign_q   <= sign_i;
            end else begin
                psum_q   <= '0;
                mcand_q  <= '0;
                mplier_q <= '0;
                sign_q   <= 1'b0;
            end
        end
    end

`ifdef MUL_PIPE_USER_EN
    logic [USER_W-1:0] user_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            user_q <= '0;
        end else if (en) begin
            user_q <= valid_i ? user_i : '0;
        end
    end

    assign user_o = user_q;
`endif

    assign valid_o  = valid_q;
    assign mcand_o  = mcand_q;
    assign mplier_o = mplier_q;
    assign psum_o   = psum_q;
    assign sign_o   = sign_q;

endmodule

// File: rtl/mul_pipeline_param.sv
// Fully pipelined WIDTH x WIDTH shift-add multiplier with full-width product,
// per-transaction signed/unsigned mode and output backpressure. Latency is WIDTH enabled
// edges, throughput one transaction per cycle.
//
// Pipeline: stage 0 registers |a|, |b| and the result sign; stages 1..WIDTH-1 each add one
// partial product; the output stage adds the final partial product, applies the negate and
// drives p_o. The whole pipeline stalls while a result is held on the output.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   valid_i, ready_o  input handshake (ready_o = ready_i | ~valid_o)
//   a_i, b_i          operands; signed_i selects two's complement
//   p_o, valid_o      product and its valid
//   ready_i           downstream accepts p_o
//   user_i, user_o    sideband tag aligned with p_o (only with MUL_PIPE_USER_EN)
//
// Optional feature: define MUL_PIPE_USER_EN to add the USER_W-bit user sideband.
module mul_pipeline_param
    import mul_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
`ifdef MUL_PIPE_USER_EN
    parameter int unsigned USER_W = 4,
`endif
    localparam int unsigned PROD_W = 2 * WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic              signed_i,
`ifdef MUL_PIPE_USER_EN
    input  logic [USER_W-1:0] user_i,
    output logic [USER_W-1:0] user_o,
`endif
    output logic [PROD_W-1:0] p_o,
    output logic              valid_o,
    input  logic              ready_i
);

    logic en;

    // Slot k of each array is the output of stage k; slot 0 is the magnitude stage.
    logic              valid_s  [WIDTH];
    logic [PROD_W-1:0] mcand_s  [WIDTH];
    logic [WIDTH-1:0]  mplier_s [WIDTH];
    logic [PROD_W-1:0] psum_s   [WIDTH];
    logic              sign_s   [WIDTH];

    logic              s0_valid_q;
    logic [PROD_W-1:0] s0_mcand_q;
    logic [WIDTH-1:0]  s0_mplier_q;
    logic              s0_sign_q;

    logic [WIDTH-1:0]  a_abs;
    logic [WIDTH-1:0]  b_abs;
    logic              sign_d;

    logic              out_valid_q;
    logic [PROD_W-1:0] out_p_q;
    logic [PROD_W-1:0] sum_fin;
    logic [PROD_W-1:0] p_d;

    assign en      = ready_i | ~out_valid_q;
    assign ready_o = en;

    always_comb begin
        a_abs  = WIDTH'(abs_val(MaxWidth'(a_i), signed_i & a_i[WIDTH-1]));
        b_abs  = WIDTH'(abs_val(MaxWidth'(b_i), signed_i & b_i[WIDTH-1]));
        sign_d = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end

    // Stage 0: operand magnitudes and result sign.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_valid_q  <= 1'b0;
            s0_mcand_q  <= '0;
            s0_mplier_q <= '0;
            s0_sign_q   <= 1'b0;
        end else if (en) begin
            s0_valid_q <= valid_i;
            if (valid_i) begin
                s0_mcand_q  <= PROD_W'(a_abs);
                s0_mplier_q <= b_abs;
                s0_sign_q   <= sign_d;
            end else begin
                s0_mcand_q  <= '0;
                s0_mplier_q <= '0;
                s0_sign_q   <= 1'b0;
            end
        end
    end

    assign valid_s[0]  = s0_valid_q;
    assign mcand_s[0]  = s0_mcand_q;
    assign mplier_s[0] = s0_mplier_q;
    assign psum_s[0]   = '0;
    assign sign_s[0]   = s0_sign_q;

`ifdef MUL_PIPE_USER_EN
    logic [USER_W-1:0] user_s [WIDTH];
    logic [USER_W-1:0] s0_user_q;
    logic [USER_W-1:0] out_user_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0_user_q  <= '0;
            out_user_q <= '0;
        end else if (en) begin
            s0_user_q  <= valid_i ? user_i : '0;
            out_user_q <= valid_s[WIDTH-1] ? user_s[WIDTH-1] : '0;
        end
    end

    assign user_s[0] = s0_user_q;
    assign user_o    = out_user_q;
`endif

    for (genvar k = 1; k < int'(WIDTH); k++) begin : g_stage
        mul_pipe_stage #(
            .WIDTH  (WIDTH)
`ifdef MUL_PIPE_USER_EN
            , .USER_W (USER_W)
`endif
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en),
            .valid_i  (valid_s[k-1]),
            .mcand_i  (mcand_s[k-1]),
            .mplier_i (mplier_s[k-1]),
            .psum_i   (psum_s[k-1]),
            .sign_i   (sign_s[k-1]),
`ifdef MUL_PIPE_USER_EN
            .user_i   (user_s[k-1]),
            .user_o   (user_s[k]),
`endif
            .valid_o  (valid_s[k]),
            .mcand_o  (mcand_s[k]),
            .mplier_o (mplier_s[k]),
            .psum_o   (psum_s[k]),
            .sign_o   (sign_s[k])
        );
    end

    // Output stage: last partial product (multiplier MSB) plus the sign correction.
    always_comb begin
        sum_fin = psum_s[WIDTH-1] + (mplier_s[WIDTH-1][0] ? mcand_s[WIDTH-1] : '0);
        p_d     = sign_s[WIDTH-1] ? PROD_W'(neg(MaxProdW'(sum_fin))) : sum_fin;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
        end else if (en) begin
            out_valid_q <= valid_s[WIDTH-1];
            out_p_q     <= valid_s[WIDTH-1] ? p_d : '0;
        end
    end

    assign valid_o = out_valid_q;
    assign p_o     = out_p_q;

endmodule

// File: tb/tb_mul_pipeline_param.sv
// Scoreboard bench for mul_pipeline_param: a WIDTH=8 and a WIDTH=4 instance.
// Drivers push expected results when a transaction is accepted; monitors pop and compare
// whenever a result is consumed (valid_o & ready_i).
module tb_mul_pipeline_param;

    typedef struct {
        logic [15:0] p;
        logic [3:0]  u;
        int          exp_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    exp_t sb8[$];
    exp_t sb4[$];

    logic        rst_n;
    logic        valid_i, ready_o, signed_i, valid_o, ready_i;
    logic [7:0]  a_i, b_i;
    logic [15:0] p_o;

    logic        v4_i, r4_o, s4_i, vo4, ri4;
    logic [3:0]  a4_i, b4_i;
    logic [7:0]  p4_o;

`ifdef MUL_PIPE_USER_EN
    logic [3:0] u8_i, u8_o, u4_i, u4_o;
`endif

    mul_pipeline_param #(.WIDTH(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .signed_i (signed_i),
`ifdef MUL_PIPE_USER_EN
        .user_i   (u8_i),
        .user_o   (u8_o),
`endif
        .p_o      (p_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    mul_pipeline_param #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (v4_i),
        .ready_o  (r4_o),
        .a_i      (a4_i),
        .b_i      (b4_i),
        .signed_i (s4_i),
`ifdef MUL_PIPE_USER_EN
        .user_i   (u4_i),
        .user_o   (u4_o),
`endif
        .p_o      (p4_o),
        .valid_o  (vo4),
        .ready_i  (ri4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
        logic signed [15:0] sa, sb;
        if (s) begin
            sa = $signed({{8{a[7]}}, a});
            sb = $signed({{8{b[7]}}, b});
            return sa * sb;
        end
        return {8'h00, a} * {8'h00, b};
    endfunction

    // Monitors sample 3 time units after the falling edge, after all stimulus changes.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (valid_o && ready_i) begin
            if (sb8.size() == 0) begin
                check("w8_unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                e = sb8.pop_front();
                check("w8_product", 32'(p_o), 32'(e.p));
                if (e.exp_cyc >= 0) check("w8_latency", 32'(cyc), 32'(e.exp_cyc));
`ifdef MUL_PIPE_USER_EN
                check("w8_user", 32'(u8_o), 32'(e.u));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (vo4 && ri4) begin
            if (sb4.size() == 0) begin
                check("w4_unexpected_valid", 32'(vo4), 32'd0);
            end else begin
                e = sb4.pop_front();
                check("w4_product", 32'(p4_o), 32'(e.p));
                if (e.exp_cyc >= 0) check("w4_latency", 32'(cyc), 32'(e.exp_cyc));
`ifdef MUL_PIPE_USER_EN
                check("w4_user", 32'(u4_o), 32'(e.u));
`endif
            end
        end
    end

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [3:0] u, input logic [15:0] exp, input bit chk_lat,
                         output int waited);
        exp_t e;
        waited = 0;
        @(negedge clk);
        a_i = a; b_i = b; signed_i = s; valid_i = 1'b1;
`ifdef MUL_PIPE_USER_EN
        u8_i = u;
`endif
        #1;
        while (!ready_o && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!ready_o) begin
            check("w8_send_timeout", 32'(ready_o), 32'd1);
            valid_i = 1'b0;
            return;
        end
        e.p = exp;
        e.u = u;
        e.exp_cyc = chk_lat ? cyc + 1 + 8 : -1;
        sb8.push_back(e);
        @(posedge clk);
        #1;
        // Garbage operands on idle cycles must not leak into the pipeline.
        valid_i = 1'b0; a_i = 8'hA5; b_i = 8'h5A; signed_i = 1'b1;
    endtask

    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic s,
                         input logic [3:0] u, input logic [7:0] exp);
        exp_t e;
        int   waited = 0;
        @(negedge clk);
        a4_i = a; b4_i = b; s4_i = s; v4_i = 1'b1;
`ifdef MUL_PIPE_USER_EN
        u4_i = u;
`endif
        #1;
        while (!r4_o && waited < 200) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!r4_o) begin
            check("w4_send_timeout", 32'(r4_o), 32'd1);
            v4_i = 1'b0;
            return;
        end
        e.p = {8'h00, exp};
        e.u = u;
        e.exp_cyc = cyc + 1 + 4;
        sb4.push_back(e);
        @(posedge clk);
        #1;
        v4_i = 1'b0; a4_i = 4'h9; b4_i = 4'h6;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while ((sb8.size() != 0 || sb4.size() != 0) && g < 200) begin
            @(negedge clk);
            #4;
            g++;
        end
        check(name, 32'(sb8.size() + sb4.size()), 32'd0);
        sb8.delete();
        sb4.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        logic [7:0]  ra, rb;
        logic        rs;
        logic [15:0] held;

        rst_n = 1'b0; valid_i = 1'b0; a_i = '0; b_i = '0; signed_i = 1'b0; ready_i = 1'b1;
        v4_i = 1'b0; a4_i = '0; b4_i = '0; s4_i = 1'b0; ri4 = 1'b1;
`ifdef MUL_PIPE_USER_EN
        u8_i = '0; u4_i = '0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("reset_valid_o", 32'(valid_o), 32'd0);
        check("reset_p_o", 32'(p_o), 32'd0);
        check("reset_ready_o", 32'(ready_o), 32'd1);
        check("reset_w4_valid_o", 32'(vo4), 32'd0);

        // 1: unsigned max, latency 8, single-cycle pulse
        send8(8'hFF, 8'hFF, 1'b0, 4'h1, 16'hFE01, 1'b1, w);
        drain("t1_drain");
        @(negedge clk);
        #4;
        check("t1_single_pulse", 32'(valid_o), 32'd0);

        // 2: signed extremes and the unsigned counterpart
        send8(8'h80, 8'h80, 1'b1, 4'h2, 16'h4000, 1'b1, w);
        send8(8'hFF, 8'h01, 1'b1, 4'h3, 16'hFFFF, 1'b1, w);
        send8(8'h80, 8'h7F, 1'b1, 4'h4, 16'hC080, 1'b1, w);
        send8(8'h00, 8'hFB, 1'b1, 4'h5, 16'h0000, 1'b1, w);
        send8(8'h80, 8'h80, 1'b0, 4'h6, 16'h4000, 1'b1, w);
        send8(8'hFD, 8'hF9, 1'b1, 4'h7, 16'h0015, 1'b1, w);
        send8(8'hC8, 8'h03, 1'b0, 4'h8, 16'h0258, 1'b1, w);
        drain("t2_drain");

        // 3: back-to-back random mixed mode
        for (int i = 0; i < 10; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            send8(ra, rb, rs, 4'(i), ref8(ra, rb, rs), 1'b1, w);
            check("t3_ready_o_high", 32'(w), 32'd0);
        end
        drain("t3_drain");

        // 4: stall with a full pipeline
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    ra = 8'(i * 7 + 3);
                    rb = 8'(8'hF0 + i);
                    rs = 1'(i);
                    send8(ra, rb, rs, 4'(i), ref8(ra, rb, rs), 1'b0, w);
                end
            end
            begin
                int g = 0;
                @(negedge clk);
                while (!valid_o && g < 100) begin
                    @(negedge clk);
                    g++;
                end
                check("t4_saw_valid", 32'(valid_o), 32'd1);
                ready_i = 1'b0;
                held = p_o;
                repeat (5) begin
                    #3;
                    check("t4_p_stable", 32'(p_o), 32'(held));
                    check("t4_valid_stable", 32'(valid_o), 32'd1);
                    check("t4_ready_o_low", 32'(ready_o), 32'd0);
                    @(negedge clk);
                end
                ready_i = 1'b1;
            end
        join
        drain("t4_drain");

        // 5: reset with four in flight
        for (int i = 0; i < 4; i++) begin
            send8(8'(i + 1), 8'h11, 1'b0, 4'h0, 16'h0000, 1'b0, w);
        end
        @(negedge clk);
        rst_n = 1'b0;
        sb8.delete();
        @(posedge clk);
        #1;
        check("t5_valid_after_reset", 32'(valid_o), 32'd0);
        check("t5_p_after_reset", 32'(p_o), 32'd0);
        check("t5_ready_after_reset", 32'(ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        send8(8'h12, 8'h34, 1'b0, 4'h9, 16'h03A8, 1'b1, w);
        send8(8'hF0, 8'h10, 1'b1, 4'hB, 16'hFF00, 1'b1, w);
        drain("t5_drain");

        // 6: WIDTH=4 instance
        send4(4'hF, 4'hF, 1'b0, 4'hA, 8'hE1);
        send4(4'h8, 4'h8, 1'b1, 4'h5, 8'h40);
        send4(4'h8, 4'h7, 1'b1, 4'h3, 8'hC8);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
